// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_seq_ctrl
// Purpose  : Sequencing controller for an N-bit up-counter. It accepts
//            start/stop/pause commands and runs the count from 0 to a
//            programmable limit in one-shot or periodic mode. Terminal count
//            is flagged with a single-cycle pulse.
// Ports    : clk       - system clock, rising edge
//            rst       - synchronous active-high reset
//            start_i   - start pulse, accepted in IDLE or DONE only
//            stop_i    - abort to IDLE from any state
//            pause_i   - level, freezes counting in RUN/HOLD
//            mode_i    - 0 one-shot, 1 periodic (latched on accepted start)
//            limit_i   - terminal value (latched on accepted start)
//            count_o   - current count (registered)
//            busy_o    - RUN or HOLD
//            paused_o  - HOLD
//            tc_o      - one-cycle terminal-count pulse
//            done_o    - DONE (one-shot finished)
// Revision : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic         pause_i,
  input  logic         mode_i,
  input  logic [N-1:0] limit_i,
  output logic [N-1:0] count_o,
  output logic         busy_o,
  output logic         paused_o,
  output logic         tc_o,
  output logic         done_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] limit_q, limit_d;
  logic         mode_q,  mode_d;
  logic         tc_q,    tc_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    tc_d    = 1'b0;

    if (stop_i) begin
      // Abort wins over every command, including a simultaneous start.
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_d = S_RUN;
            count_d = '0;
            limit_d = limit_i;
            mode_d  = mode_i;
          end
        end
        S_RUN: begin
          // Pause is checked before the terminal compare, so a pause that
          // lands on the terminal cycle defers the tc pulse.
          if (pause_i) begin
            state_d = S_HOLD;
          end else if (count_q == limit_q) begin
            tc_d = 1'b1;
            if (mode_q) begin
              count_d = '0;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        S_HOLD: begin
          // Leaving HOLD does not count; counting resumes one edge later.
          if (!pause_i) begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = S_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      tc_q    <= tc_d;
    end
  end

  // Status flags decode only the state register: no input-to-output path.
  assign count_o  = count_q;
  assign busy_o   = (state_q == S_RUN) || (state_q == S_HOLD);
  assign paused_o = (state_q == S_HOLD);
  assign done_o   = (state_q == S_DONE);
  assign tc_o     = tc_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_seq_ctrl
// Purpose  : Directed bench for counter_seq_ctrl. Each driven cycle pushes
//            the hand-computed post-edge outputs into a queue; an independent
//            monitor pops one entry per cycle and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_seq_ctrl;

  localparam int N = 4;

  // Flag nibble {busy, paused, tc, done}
  localparam logic [3:0] IDL = 4'b0000;
  localparam logic [3:0] RN  = 4'b1000;
  localparam logic [3:0] RNT = 4'b1010;
  localparam logic [3:0] HLD = 4'b1100;
  localparam logic [3:0] DN  = 4'b0001;
  localparam logic [3:0] DNT = 4'b0011;

  logic         clk = 1'b0;
  logic         rst, start_i, stop_i, pause_i, mode_i;
  logic [N-1:0] limit_i;
  logic [N-1:0] count_o;
  logic         busy_o, paused_o, tc_o, done_o;

  typedef struct {
    string      name;
    logic [7:0] v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  counter_seq_ctrl #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .stop_i   (stop_i),
    .pause_i  (pause_i),
    .mode_i   (mode_i),
    .limit_i  (limit_i),
    .count_o  (count_o),
    .busy_o   (busy_o),
    .paused_o (paused_o),
    .tc_o     (tc_o),
    .done_o   (done_o)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a falling edge; the following rising
  // edge samples them and the expected outputs are checked at the next
  // falling edge.
  task automatic cyc(input string nm, input logic r, input logic st,
                     input logic sp, input logic ps, input logic m,
                     input logic [3:0] lim, input logic [3:0] ec,
                     input logic [3:0] fl);
    exp_t e;
    @(negedge clk);
    #1;
    rst     = r;
    start_i = st;
    stop_i  = sp;
    pause_i = ps;
    mode_i  = m;
    limit_i = lim;
    e.name  = nm;
    e.v     = {ec, fl};
    q.push_back(e);
  endtask

  // Monitor: one scoreboard entry per rising edge, checked at the falling edge.
  initial begin : monitor
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {count_o, busy_o, paused_o, tc_o, done_o};
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s: got count=%0d busy/paused/tc/done=%b, required count=%0d busy/paused/tc/done=%b",
                   e.name, act[7:4], act[3:0], e.v[7:4], e.v[3:0]);
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; pause_i = 1'b0;
    mode_i = 1'b0; limit_i = '0;

    cyc("reset0", 1, 0, 0, 0, 0, 0, 0, IDL);
    cyc("reset1", 1, 0, 0, 0, 0, 0, 0, IDL);
    cyc("idle",   0, 0, 0, 0, 0, 0, 0, IDL);

    // One-shot limit=3; limit/mode wiggled afterwards must have no effect.
    cyc("os3_start", 0, 1, 0, 0, 0, 3, 0, RN);
    cyc("os3_c1",    0, 0, 0, 0, 1, 9, 1, RN);
    cyc("os3_c2",    0, 0, 0, 0, 1, 9, 2, RN);
    cyc("os3_c3",    0, 0, 0, 0, 1, 9, 3, RN);
    cyc("os3_tc",    0, 0, 0, 0, 1, 9, 3, DNT);
    cyc("os3_done",  0, 0, 0, 0, 1, 9, 3, DN);

    // Restart from DONE with a new limit=1.
    cyc("re1_start", 0, 1, 0, 0, 0, 1, 0, RN);
    cyc("re1_c1",    0, 0, 0, 0, 0, 0, 1, RN);
    cyc("re1_tc",    0, 0, 0, 0, 0, 0, 1, DNT);
    cyc("re1_done",  0, 0, 0, 0, 0, 0, 1, DN);

    // Periodic limit=2.
    cyc("per2_start", 0, 1, 0, 0, 1, 2, 0, RN);
    cyc("per2_c1",    0, 0, 0, 0, 0, 0, 1, RN);
    cyc("per2_c2",    0, 0, 0, 0, 0, 0, 2, RN);
    cyc("per2_wrap1", 0, 0, 0, 0, 0, 0, 0, RNT);
    cyc("per2_c1b",   0, 0, 0, 0, 0, 0, 1, RN);
    cyc("per2_c2b",   0, 0, 0, 0, 0, 0, 2, RN);
    cyc("per2_wrap2", 0, 0, 0, 0, 0, 0, 0, RNT);
    cyc("per2_c1c",   0, 0, 0, 0, 0, 0, 1, RN);
    cyc("per2_stop",  0, 0, 1, 0, 0, 0, 0, IDL);

    // Start together with stop: stop wins.
    cyc("start_stop", 0, 1, 1, 0, 0, 5, 0, IDL);

    // One-shot limit=5 with a 3-cycle pause at count=2.
    cyc("pz_start", 0, 1, 0, 0, 0, 5, 0, RN);
    cyc("pz_c1",    0, 0, 0, 0, 0, 0, 1, RN);
    cyc("pz_c2",    0, 0, 0, 0, 0, 0, 2, RN);
    cyc("pz_h1",    0, 0, 0, 1, 0, 0, 2, HLD);
    cyc("pz_h2",    0, 0, 0, 1, 0, 0, 2, HLD);
    cyc("pz_h3",    0, 0, 0, 1, 0, 0, 2, HLD);
    cyc("pz_resume",0, 0, 0, 0, 0, 0, 2, RN);
    cyc("pz_c3",    0, 0, 0, 0, 0, 0, 3, RN);
    cyc("pz_c4",    0, 0, 0, 0, 0, 0, 4, RN);
    cyc("pz_c5",    0, 0, 0, 0, 0, 0, 5, RN);
    cyc("pz_tc",    0, 0, 0, 0, 0, 0, 5, DNT);

    // Start during RUN is ignored: limit 6 and one-shot mode are kept.
    cyc("ig_start", 0, 1, 0, 0, 0, 6, 0, RN);
    cyc("ig_c1",    0, 0, 0, 0, 0, 0, 1, RN);
    cyc("ig_c2",    0, 0, 0, 0, 0, 0, 2, RN);
    cyc("ig_restart",0, 1, 0, 0, 1, 1, 3, RN);
    cyc("ig_c4",    0, 0, 0, 0, 0, 0, 4, RN);
    cyc("ig_c5",    0, 0, 0, 0, 0, 0, 5, RN);
    cyc("ig_c6",    0, 0, 0, 0, 0, 0, 6, RN);
    cyc("ig_tc",    0, 0, 0, 0, 0, 0, 6, DNT);

    // Stop at count=4: back to IDLE, no tc, no done.
    cyc("sp_start", 0, 1, 0, 0, 0, 9, 0, RN);
    for (int k = 1; k <= 4; k++) cyc("sp_cnt", 0, 0, 0, 0, 0, 0, 4'(k), RN);
    cyc("sp_stop",  0, 0, 1, 0, 0, 0, 0, IDL);
    cyc("sp_after", 0, 0, 0, 0, 0, 0, 0, IDL);

    // Pause with start in IDLE enters RUN; pause on terminal count defers tc.
    cyc("ps_start", 0, 1, 0, 1, 0, 1, 0, RN);
    cyc("ps_hold",  0, 0, 0, 1, 0, 0, 0, HLD);
    cyc("ps_run",   0, 0, 0, 0, 0, 0, 0, RN);
    cyc("ps_c1",    0, 0, 0, 0, 0, 0, 1, RN);
    cyc("ps_tcdef", 0, 0, 0, 1, 0, 0, 1, HLD);
    cyc("ps_rel",   0, 0, 0, 0, 0, 0, 1, RN);
    cyc("ps_tc",    0, 0, 0, 0, 0, 0, 1, DNT);

    // limit=0 one-shot: done one edge after start.
    cyc("l0os_start", 0, 1, 0, 0, 0, 0, 0, RN);
    cyc("l0os_tc",    0, 0, 0, 0, 0, 0, 0, DNT);
    cyc("l0os_done",  0, 0, 0, 0, 0, 0, 0, DN);

    // limit=0 periodic: tc on every unpaused RUN cycle.
    cyc("l0p_start", 0, 1, 0, 0, 1, 0, 0, RN);
    cyc("l0p_tc1",   0, 0, 0, 0, 0, 0, 0, RNT);
    cyc("l0p_tc2",   0, 0, 0, 0, 0, 0, 0, RNT);
    cyc("l0p_hold",  0, 0, 0, 1, 0, 0, 0, HLD);
    cyc("l0p_run",   0, 0, 0, 0, 0, 0, 0, RN);
    cyc("l0p_tc3",   0, 0, 0, 0, 0, 0, 0, RNT);
    cyc("l0p_stop",  0, 0, 1, 0, 0, 0, 0, IDL);

    // limit=15 periodic: full range, reload to 0 with tc every 16 cycles.
    cyc("l15_start", 0, 1, 0, 0, 1, 15, 0, RN);
    for (int w = 0; w < 2; w++) begin
      for (int k = 1; k <= 15; k++) cyc("l15_cnt", 0, 0, 0, 0, 0, 0, 4'(k), RN);
      cyc("l15_wrap", 0, 0, 0, 0, 0, 0, 0, RNT);
    end
    cyc("l15_stop", 0, 0, 1, 0, 0, 0, 0, IDL);

    // Reset for 2 edges mid-run at count=5.
    cyc("rs_start", 0, 1, 0, 0, 0, 9, 0, RN);
    for (int k = 1; k <= 5; k++) cyc("rs_cnt", 0, 0, 0, 0, 0, 0, 4'(k), RN);
    cyc("rs_rst0",  1, 0, 0, 0, 0, 0, 0, IDL);
    cyc("rs_rst1",  1, 0, 0, 0, 0, 0, 0, IDL);
    cyc("rs_after", 0, 0, 0, 0, 0, 0, 0, IDL);

    // Let the monitor drain the queue, bounded.
    for (int t = 0; t < 10; t++) begin
      @(posedge clk);
      if (q.size() == 0) break;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d entries left, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
